// File: rtl/freq_meter.sv
// Gated frequency counter: synchronizes sig_in and counts its rising edges over
// back-to-back windows of GATE_CYCLES clk cycles, latching the saturated result.
module freq_meter #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam int SW = $clog2(SYNC_STAGES);
    localparam logic [GW-1:0]    GATE_LAST   = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]    GATE_ONE    = GW'(1);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SYNC_STAGES - 1);
    localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic [SW-1:0]          settle_cnt_q;
    logic [GW-1:0]          gate_cnt_q;
    logic [CNT_W-1:0]       edge_cnt_q;
    logic                   sat_q;
    logic [CNT_W-1:0]       freq_q;
    logic                   freq_valid_q;
    logic                   overflow_q;
    logic                   busy_q;

    logic                   rise_d;
    logic                   sat_hit_d;
    logic                   sat_d;
    logic [CNT_W-1:0]       edge_sum_d;

    // Input synchronizer and one-cycle history for edge detection, free-running in all states.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Rising-edge detect and saturating sum of the running count plus this cycle's edge.
    always_comb begin
        rise_d    = sync_q[SYNC_STAGES-1] & ~s_prev_q;
        sat_hit_d = rise_d & (edge_cnt_q == CNT_MAX);
        sat_d     = sat_q | sat_hit_d;
        if (sat_d) begin
            edge_sum_d = CNT_MAX;
        end else if (rise_d) begin
            edge_sum_d = edge_cnt_q + CNT_ONE;
        end else begin
            edge_sum_d = edge_cnt_q;
        end
    end

    // Measurement FSM with counters and registered result outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            sat_q        <= 1'b0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            freq_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    settle_cnt_q <= '0;
                    gate_cnt_q   <= '0;
                    edge_cnt_q   <= '0;
                    sat_q        <= 1'b0;
                    busy_q       <= en;
                    state_q      <= en ? ST_SETTLE : ST_IDLE;
                end
                ST_SETTLE: begin
                    busy_q <= en;
                    if (!en) begin
                        settle_cnt_q <= '0;
                        state_q      <= ST_IDLE;
                    end else if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_q <= '0;
                        state_q      <= ST_GATE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SETTLE_ONE;
                    end
                end
                ST_GATE: begin
                    if (gate_cnt_q == GATE_LAST) begin
                        // Window completes regardless of en; en only decides whether another starts.
                        freq_q       <= edge_sum_d;
                        overflow_q   <= sat_d;
                        freq_valid_q <= 1'b1;
                        gate_cnt_q   <= '0;
                        edge_cnt_q   <= '0;
                        sat_q        <= 1'b0;
                        busy_q       <= en;
                        state_q      <= en ? ST_GATE : ST_IDLE;
                    end else if (!en) begin
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        sat_q      <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + GATE_ONE;
                        edge_cnt_q <= edge_sum_d;
                        sat_q      <= sat_d;
                        busy_q     <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign freq       = freq_q;
    assign freq_valid = freq_valid_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter with GATE_CYCLES=100: a 32-bit instance and a 3-bit
// instance for saturation, results checked against a queue of expected windows.
module tb_freq_meter;
    logic        clk;
    logic        nrst;
    logic        en_a, sig_a, en_b, sig_b;
    logic [31:0] freq_a;
    logic        valid_a, ovf_a, busy_a;
    logic [2:0]  freq_b;
    logic        valid_b, ovf_b, busy_b;

    typedef struct {
        logic [31:0] freq;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(32), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .nrst(nrst), .en(en_a), .sig_in(sig_a),
        .freq(freq_a), .freq_valid(valid_a), .overflow(ovf_a), .busy(busy_a)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(3), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .nrst(nrst), .en(en_b), .sig_in(sig_b),
        .freq(freq_b), .freq_valid(valid_b), .overflow(ovf_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: inputs set beforehand are sampled at the posedge, outputs observed at the negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        nrst = 1'b1;
        en_a = 1'b0; sig_a = 1'b0; en_b = 1'b0; sig_b = 1'b0;
        #2 nrst = 1'b0;
        #1;
        checks++; if (freq_a !== 32'd0) begin errors++; $display("FAIL reset_freq: got %0d expected 0", freq_a); end
        checks++; if ({valid_a, ovf_a, busy_a} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {valid_a, ovf_a, busy_a}); end
        checks++; if ({freq_b, valid_b, ovf_b, busy_b} !== 6'd0) begin errors++; $display("FAIL reset_b: got %b expected 0", {freq_b, valid_b, ovf_b, busy_b}); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        step();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy_a); end
    endtask

    // Period-10 input with en held: three back-to-back windows, then still running at gate_cnt=50.
    task automatic test_periodic();
        exp_t e;
        int   last_v;
        last_v = -1;
        for (int k = 0; k < 3; k++) exp_q.push_back('{freq: 32'd10, ovf: 1'b0});
        en_a = 1'b1;
        for (int i = 0; i <= 352; i++) begin
            sig_a = ((i % 10) < 5);
            step();
            if (i == 1) begin
                checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL periodic_busy: got %b expected 1", busy_a); end
            end
            if (valid_a) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL periodic_extra_valid: got valid at %0d expected none", i);
                end else begin
                    e = exp_q.pop_front();
                    if (freq_a !== e.freq || ovf_a !== e.ovf) begin
                        errors++; $display("FAIL periodic_freq: got %0d/%b expected %0d/%b", freq_a, ovf_a, e.freq, e.ovf);
                    end
                end
                checks++;
                if (last_v < 0) begin
                    if (i != 102) begin errors++; $display("FAIL periodic_latency: got %0d expected 102", i); end
                end else if (i - last_v != 100) begin
                    errors++; $display("FAIL periodic_spacing: got %0d expected 100", i - last_v);
                end
                last_v = i;
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL periodic_missing: got %0d pending expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    // Dropping en mid-window discards the partial count and leaves the last result alone.
    task automatic test_abort();
        en_a = 1'b0;
        for (int i = 353; i <= 420; i++) begin
            sig_a = ((i % 10) < 5);
            step();
            if (i == 353) begin
                checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy_a); end
            end
            if (valid_a) begin
                checks++; errors++; $display("FAIL abort_valid: got valid at %0d expected none", i);
            end
        end
        checks++; if (freq_a !== 32'd10 || ovf_a !== 1'b0) begin errors++; $display("FAIL abort_hold: got %0d/%b expected 10/0", freq_a, ovf_a); end
    endtask

    // Input already high at enable, then constant low: no edges in either window.
    task automatic test_zero();
        exp_t e;
        sig_a = 1'b1;
        repeat (5) step();
        exp_q.push_back('{freq: 32'd0, ovf: 1'b0});
        exp_q.push_back('{freq: 32'd0, ovf: 1'b0});
        en_a = 1'b1;
        for (int i = 0; i <= 202; i++) begin
            sig_a = (i < 102);
            step();
            if (valid_a) begin
                checks++;
                if (exp_q.size() == 0 || (i != 102 && i != 202)) begin
                    errors++; $display("FAIL zero_valid: got valid at %0d expected 102 or 202", i);
                end else begin
                    e = exp_q.pop_front();
                    if (freq_a !== e.freq) begin errors++; $display("FAIL zero_freq: got %0d expected %0d", freq_a, e.freq); end
                end
            end
        end
        en_a = 1'b0;
        step();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL zero_missing: got %0d pending expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    // 3-bit counter: 25 edges saturate to 7 with overflow, then 5 edges clear it.
    task automatic test_saturate();
        exp_t e;
        exp_q.push_back('{freq: 32'd7, ovf: 1'b1});
        exp_q.push_back('{freq: 32'd5, ovf: 1'b0});
        en_b = 1'b1;
        for (int i = 0; i <= 202; i++) begin
            sig_b = (i <= 100) ? ((i % 4) < 2) : ((i % 20) < 10);
            step();
            if (valid_b) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sat_extra_valid: got valid at %0d expected none", i);
                end else begin
                    e = exp_q.pop_front();
                    if (freq_b !== e.freq[2:0] || ovf_b !== e.ovf) begin
                        errors++; $display("FAIL sat_freq: got %0d/%b expected %0d/%b", freq_b, ovf_b, e.freq[2:0], e.ovf);
                    end
                end
            end
        end
        en_b = 1'b0;
        step();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sat_missing: got %0d pending expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    // Edges on the last gate cycle land in the closing window; window totals sum to all edges.
    task automatic test_boundary();
        exp_t e;
        int   total;
        total = 0;
        sig_a = 1'b0;
        step();
        exp_q.push_back('{freq: 32'd1, ovf: 1'b0});
        exp_q.push_back('{freq: 32'd2, ovf: 1'b0});
        exp_q.push_back('{freq: 32'd0, ovf: 1'b0});
        en_a = 1'b1;
        for (int i = 0; i <= 302; i++) begin
            sig_a = (i == 100 || i == 101 || i == 150 || i == 151 || i == 200 || i == 201);
            step();
            if (valid_a) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL boundary_extra_valid: got valid at %0d expected none", i);
                end else begin
                    e = exp_q.pop_front();
                    total += int'(freq_a);
                    if (freq_a !== e.freq) begin errors++; $display("FAIL boundary_freq: got %0d expected %0d at %0d", freq_a, e.freq, i); end
                end
            end
        end
        en_a = 1'b0;
        step();
        checks++; if (total != 3) begin errors++; $display("FAIL boundary_total: got %0d expected 3", total); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL boundary_missing: got %0d pending expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    // Async reset mid-gate clears outputs at once; restart latency is 103 edges.
    task automatic test_async_reset();
        exp_t e;
        int   seen;
        seen = 0;
        exp_q.push_back('{freq: 32'd10, ovf: 1'b0});
        en_a = 1'b1;
        for (int i = 0; i <= 150; i++) begin
            sig_a = ((i % 10) < 5);
            step();
            if (valid_a) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL arst_pre_valid: got valid at %0d expected none", i);
                end else begin
                    e = exp_q.pop_front();
                    if (freq_a !== e.freq) begin errors++; $display("FAIL arst_pre_freq: got %0d expected %0d", freq_a, e.freq); end
                end
            end
        end
        #2 nrst = 1'b0;
        #1;
        checks++; if (freq_a !== 32'd0) begin errors++; $display("FAIL arst_freq: got %0d expected 0", freq_a); end
        checks++; if ({valid_a, ovf_a, busy_a} !== 3'b000) begin errors++; $display("FAIL arst_flags: got %b expected 000", {valid_a, ovf_a, busy_a}); end
        checks++; if (freq_b !== 3'd0) begin errors++; $display("FAIL arst_freq_b: got %0d expected 0", freq_b); end
        exp_q.delete();
        @(negedge clk);
        nrst = 1'b1;
        exp_q.push_back('{freq: 32'd10, ovf: 1'b0});
        for (int i = 0; i <= 102; i++) begin
            sig_a = ((i % 10) < 5);
            step();
            if (valid_a) begin
                seen++;
                checks++;
                if (i != 102 || exp_q.size() == 0) begin
                    errors++; $display("FAIL arst_latency: got valid at edge %0d expected 103", i + 1);
                end else begin
                    e = exp_q.pop_front();
                    if (freq_a !== e.freq) begin errors++; $display("FAIL arst_freq_after: got %0d expected %0d", freq_a, e.freq); end
                end
            end
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL arst_valid_count: got %0d expected 1", seen); end
        en_a = 1'b0;
        step();
        exp_q.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_periodic();
        test_abort();
        test_zero();
        test_saturate();
        test_boundary();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
